// File: rtl/data_mem_unit.sv
// Byte/half/word data memory for the load/store stage with a valid/ready request
// port, one-cycle pipelined responses and a hardware clear sequencer.
module data_mem_unit #(
   parameter int  DATA_W     = 32,
   parameter int  ADDR_W     = 5,
   parameter bit  CLR_ON_RST = 1'b1,
   localparam int NB         = DATA_W / 8,
   localparam int OFF_W      = $clog2(NB),
   localparam int BA_W       = ADDR_W + OFF_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              clr_busy,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [BA_W-1:0]   req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {ST_CLR, ST_RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic [ADDR_W-1:0]   word;
   logic [OFF_W-1:0]    off;
   logic                acc_err;
   logic                accept;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_wa;
   logic [NB-1:0]       mem_be;
   logic [DATA_W-1:0]   mem_wd;

   // Access wider than the word, or offset not aligned to the access size.
   function automatic logic size_err(input logic [1:0] sz, input logic [OFF_W-1:0] o);
      int nbytes;
      nbytes = 1 << sz;
      return (nbytes > NB) || ((int'(o) & (nbytes - 1)) != 0);
   endfunction

   function automatic logic [NB-1:0] byte_en(input logic [1:0] sz, input logic [OFF_W-1:0] o);
      logic [NB-1:0] be;
      int            lo, hi;
      lo = int'(o);
      hi = lo + (1 << sz);
      for (int j = 0; j < NB; j++) be[j] = (j >= lo) && (j < hi);
      return be;
   endfunction

   // Data arrives right-aligned; keep the low 8*2**sz bits and extend above them.
   function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] sz, input logic sgn);
      logic [DATA_W-1:0] keep;
      logic              msb;
      int                nbits;
      nbits = 8 << sz;
      if (nbits >= DATA_W) return d;
      keep = {DATA_W{1'b1}} >> (DATA_W - nbits);
      msb  = 1'b0;
      for (int i = 0; i < DATA_W; i++) if (i == nbits - 1) msb = d[i];
      return (d & keep) | ((sgn && msb) ? ~keep : '0);
   endfunction

   always_comb begin
      word        = req_addr[BA_W-1:OFF_W];
      off         = req_addr[OFF_W-1:0];
      acc_err     = size_err(req_size, off);
      req_ready   = (state_q == ST_RUN) && !clr_req;
      accept      = req_valid && req_ready;
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      mem_we      = 1'b0;
      mem_wa      = word;
      mem_be      = byte_en(req_size, off);
      mem_wd      = req_wdata << {off, 3'b000};
      rsp_valid_d = accept;
      rsp_err_d   = accept && acc_err;
      rsp_rdata_d = '0;
      case (state_q)
         ST_CLR: begin
            mem_we = 1'b1;
            mem_wa = clr_cnt_q;
            mem_be = '1;
            mem_wd = '0;
            if (clr_cnt_q == '1) begin
               state_d   = ST_RUN;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         default: begin
            if (clr_req) begin
               state_d   = ST_CLR;
               clr_cnt_d = '0;
            end
            if (accept && !acc_err) begin
               if (req_we) mem_we = 1'b1;
               else rsp_rdata_d = load_ext(mem_q[word] >> {off, 3'b000}, req_size, req_signed);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLR_ON_RST ? ST_CLR : ST_RUN;
         clr_cnt_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Array is not reset; the clear sequencer is the only way to zero it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int j = 0; j < NB; j++) begin
            if (mem_be[j]) mem_q[mem_wa][8*j +: 8] <= mem_wd[8*j +: 8];
         end
      end
   end

   assign clr_busy  = (state_q == ST_CLR);
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: vector table plus hand sequences for clear and reset,
// responses checked against a queue of expected results.
module tb_data_mem_unit;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int BA_W   = 7;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clr_req = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_we = 1'b0;
   logic [1:0]        req_size = 2'd0;
   logic              req_signed = 1'b0;
   logic [BA_W-1:0]   req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              clr_busy, req_ready, rsp_valid, rsp_err;
   logic [DATA_W-1:0] rsp_rdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic              err;
      logic [DATA_W-1:0] rdata;
   } exp_t;

   typedef struct {
      logic              we;
      logic [1:0]        sz;
      logic              sgn;
      logic [BA_W-1:0]   addr;
      logic [DATA_W-1:0] wd;
      logic              err;
      logic [DATA_W-1:0] rd;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[$];
   logic acc_d;

   always #5 clk = ~clk;

   data_mem_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLR_ON_RST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(clr_busy),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
      .rsp_rdata(rsp_rdata)
   );

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // A response is due exactly one cycle after each accepted request.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_d <= 1'b0;
      else acc_d <= req_valid & req_ready;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         exp_t e;
         check("rsp_valid_timing", DATA_W'(rsp_valid), DATA_W'(acc_d));
         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got response 0x%08h with nothing expected", rsp_rdata);
            end else begin
               e = sb_q.pop_front();
               check("rsp_err", DATA_W'(rsp_err), DATA_W'(e.err));
               check("rsp_rdata", rsp_rdata, e.rdata);
            end
         end else begin
            check("idle_rdata", rsp_rdata, '0);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [BA_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input logic e_err, input logic [DATA_W-1:0] e_rd);
      int n = 0;
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = a;
      req_wdata  = wd;
      sb_q.push_back('{err: e_err, rdata: e_rd});
      forever begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: ready low for %0d cycles, required high", n);
            break;
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Counts negedges with clr_busy high; optionally pulses clr_req mid-clear.
   task automatic count_busy(input bit pulse, output int n);
      n = 0;
      forever begin
         @(negedge clk);
         if (!clr_busy) break;
         n++;
         clr_req = pulse && (n == 5);
         if (n > 200) break;
      end
      clr_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs.push_back('{1'b1, 2'd2, 1'b0, 7'h10, 32'hDEADBEEF, 1'b0, 32'h00000000});
      vecs.push_back('{1'b0, 2'd0, 1'b1, 7'h11, 32'h0,        1'b0, 32'hFFFFFFBE});
      vecs.push_back('{1'b0, 2'd0, 1'b0, 7'h11, 32'h0,        1'b0, 32'h000000BE});
      vecs.push_back('{1'b0, 2'd1, 1'b1, 7'h12, 32'h0,        1'b0, 32'hFFFFDEAD});
      vecs.push_back('{1'b0, 2'd1, 1'b0, 7'h10, 32'h0,        1'b0, 32'h0000BEEF});
      vecs.push_back('{1'b1, 2'd0, 1'b0, 7'h13, 32'h0000005A, 1'b0, 32'h00000000});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 7'h10, 32'h0,        1'b0, 32'h5AADBEEF});
      vecs.push_back('{1'b0, 2'd0, 1'b1, 7'h13, 32'h0,        1'b0, 32'h0000005A});
      vecs.push_back('{1'b1, 2'd1, 1'b0, 7'h01, 32'h00001234, 1'b1, 32'h00000000});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 7'h02, 32'h0,        1'b1, 32'h00000000});
      vecs.push_back('{1'b0, 2'd3, 1'b0, 7'h00, 32'h0,        1'b1, 32'h00000000});
      vecs.push_back('{1'b1, 2'd3, 1'b0, 7'h10, 32'hFFFFFFFF, 1'b1, 32'h00000000});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 7'h10, 32'h0,        1'b0, 32'h5AADBEEF});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 7'h00, 32'h0,        1'b0, 32'h00000000});
      vecs.push_back('{1'b1, 2'd1, 1'b0, 7'h06, 32'h00008001, 1'b0, 32'h00000000});
      vecs.push_back('{1'b0, 2'd1, 1'b1, 7'h06, 32'h0,        1'b0, 32'hFFFF8001});
      vecs.push_back('{1'b0, 2'd2, 1'b0, 7'h04, 32'h0,        1'b0, 32'h80010000});
      vecs.push_back('{1'b1, 2'd0, 1'b0, 7'h04, 32'hFFFFFF77, 1'b0, 32'h00000000});
      vecs.push_back('{1'b0, 2'd2, 1'b1, 7'h04, 32'h0,        1'b0, 32'h80010077});
      vecs.push_back('{1'b1, 2'd2, 1'b0, 7'h7C, 32'h11223344, 1'b0, 32'h00000000});
      vecs.push_back('{1'b0, 2'd0, 1'b0, 7'h7F, 32'h0,        1'b0, 32'h00000011});
      vecs.push_back('{1'b0, 2'd1, 1'b1, 7'h7C, 32'h0,        1'b0, 32'h00003344});
      vecs.push_back('{1'b0, 2'd0, 1'b1, 7'h7E, 32'h0,        1'b0, 32'h00000022});
      vecs.push_back('{1'b0, 2'd1, 1'b0, 7'h03, 32'h0,        1'b1, 32'h00000000});

      // Reset state and initial clear
      repeat (2) @(posedge clk);
      #1;
      check("rst_clr_busy", DATA_W'(clr_busy), DATA_W'(1));
      check("rst_req_ready", DATA_W'(req_ready), '0);
      check("rst_rsp_valid", DATA_W'(rsp_valid), '0);
      check("rst_rsp_err", DATA_W'(rsp_err), '0);
      check("rst_rsp_rdata", rsp_rdata, '0);
      rst_n = 1'b1;
      count_busy(1'b0, n);
      check("init_clear_cycles", DATA_W'(n), DATA_W'(32));
      check("ready_after_clear", DATA_W'(req_ready), DATA_W'(1));
      @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) do_req(1'b0, 2'd2, 1'b0, BA_W'(i * 4), '0, 1'b0, '0);

      // Vector table, applied back to back
      foreach (vecs[i])
         do_req(vecs[i].we, vecs[i].sz, vecs[i].sgn, vecs[i].addr, vecs[i].wd,
                vecs[i].err, vecs[i].rd);

      // clr_req together with a request: request must wait out the clear
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_size   = 2'd2;
      req_signed = 1'b0;
      req_addr   = 7'h10;
      clr_req    = 1'b1;
      sb_q.push_back('{err: 1'b0, rdata: 32'h0});
      @(negedge clk);
      check("clr_req_blocks_ready", DATA_W'(req_ready), '0);
      @(posedge clk);
      #1;
      clr_req = 1'b0;
      check("clr_busy_on_req", DATA_W'(clr_busy), DATA_W'(1));
      count_busy(1'b1, n);
      check("clr_req_cycles", DATA_W'(n), DATA_W'(32));
      check("held_req_ready", DATA_W'(req_ready), DATA_W'(1));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      do_req(1'b0, 2'd2, 1'b0, 7'h7C, '0, 1'b0, '0);
      do_req(1'b0, 2'd2, 1'b0, 7'h04, '0, 1'b0, '0);

      // Reset while a response is in flight, then again mid-clear
      do_req(1'b1, 2'd2, 1'b0, 7'h10, 32'hCAFEF00D, 1'b0, '0);
      do_req(1'b0, 2'd2, 1'b0, 7'h10, '0, 1'b0, 32'hCAFEF00D);
      rst_n = 1'b0;
      #1;
      check("rst_drops_rsp_valid", DATA_W'(rsp_valid), '0);
      check("rst_drops_rsp_rdata", rsp_rdata, '0);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midclr_rst_clr_busy", DATA_W'(clr_busy), DATA_W'(1));
      check("midclr_rst_req_ready", DATA_W'(req_ready), '0);
      check("midclr_rst_rsp_valid", DATA_W'(rsp_valid), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      count_busy(1'b0, n);
      check("restart_clear_cycles", DATA_W'(n), DATA_W'(32));
      @(posedge clk);
      #1;
      do_req(1'b0, 2'd2, 1'b0, 7'h10, '0, 1'b0, '0);
      do_req(1'b0, 2'd2, 1'b0, 7'h7C, '0, 1'b0, '0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", DATA_W'(sb_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
